usb_tx_packet_buf: RTL and testbench

Packet buffer and feeder that sits directly upstream of the USB transmit engine (`usb_tx`) in the `clk48_i` domain. Endpoint/protocol logic writes complete packets byte-by-byte: the PID byte first, then payload, with a last-byte marker. Only fully committed packets are released. The block pulses the send request, feeds the bytes over the `txAcceptNewData`/`txDataValid` handshake, tags the final byte, and reports completion once the line returns idle.

---
 rtl/usb_tx_packet_buf.sv | 163 ++++++++++++++++
 tb/tb_usb_tx_packet_buf.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_packet_buf.sv
// Packet buffer feeding the USB transmit engine. Packets are written byte by
// byte, released only once committed, then streamed out over the
// txAcceptNewData/txDataValid handshake with completion reported on idle.
module usb_tx_packet_buf #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk48_i,
    input  logic              rst_n_i,
    input  logic [7:0]        wrData_i,
    input  logic              wrValid_i,
    input  logic              wrLast_i,
    input  logic              wrDiscard_i,
    output logic              wrReady_o,
    output logic              wrOverflow_o,
    output logic [ADDR_W:0]   pktCount_o,
    output logic              txReqSendPacket_o,
    input  logic              txAcceptNewData_i,
    output logic              txDataValid_o,
    output logic              txIsLastByte_o,
    output logic [7:0]        txData_o,
    input  logic              txSending_i,
    output logic              sendDone_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FEED,
        DRAIN
    } state_t;

    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_FILL = (ADDR_W + 1)'(DEPTH);

    state_t          state;
    state_t          stateNext;
    logic [8:0]      mem [DEPTH];
    logic [ADDR_W:0] wrPtr;
    logic [ADDR_W:0] commitPtr;
    logic [ADDR_W:0] rdPtr;
    logic [ADDR_W:0] pktCount;
    logic [ADDR_W:0] fill;
    logic            full;
    logic            noCommitted;
    logic            wrAccept;
    logic            wrCommit;
    logic            rdHandshake;
    logic            rdLast;
    logic            seen;
    logic [8:0]      rdEntry;

    assign fill        = wrPtr - rdPtr;
    assign full        = (fill == FULL_FILL);
    assign noCommitted = (commitPtr == rdPtr);
    assign wrReady_o   = ~full & ~wrDiscard_i;
    assign wrAccept    = wrValid_i & wrReady_o;
    assign wrCommit    = wrAccept & wrLast_i;
    assign rdEntry     = mem[rdPtr[ADDR_W-1:0]];
    assign rdHandshake = (state == FEED) & txAcceptNewData_i;
    assign rdLast      = rdHandshake & rdEntry[8];
    assign pktCount_o  = pktCount;

    // Storage array: {last, data} per entry, written on every accepted byte.
    always_ff @(posedge clk48_i) begin
        if (wrAccept) begin
            mem[wrPtr[ADDR_W-1:0]] <= {wrLast_i, wrData_i};
        end
    end

    // Write side: discard, auto-drop of oversized packets, append and commit.
    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wrPtr        <= '0;
            commitPtr    <= '0;
            wrOverflow_o <= 1'b0;
        end else begin
            wrOverflow_o <= 1'b0;
            if (wrDiscard_i) begin
                wrPtr <= commitPtr;
            end else if (full && noCommitted) begin
                wrPtr        <= commitPtr;
                wrOverflow_o <= 1'b1;
            end else if (wrAccept) begin
                wrPtr <= wrPtr + PTR_ONE;
                if (wrLast_i) begin
                    commitPtr <= wrPtr + PTR_ONE;
                end
            end
        end
    end

    // Committed packet count; a commit and a final-byte handshake cancel out.
    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pktCount <= '0;
        end else begin
            case ({wrCommit, rdLast})
                2'b10:   pktCount <= pktCount + PTR_ONE;
                2'b01:   pktCount <= pktCount - PTR_ONE;
                default: pktCount <= pktCount;
            endcase
        end
    end

    // Reader state, read pointer and the tx-busy-observed flag.
    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            rdPtr <= '0;
            seen  <= 1'b0;
        end else begin
            state <= stateNext;
            if (rdHandshake) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            if (state == DRAIN) begin
                if (sendDone_o) begin
                    seen <= 1'b0;
                end else if (txSending_i) begin
                    seen <= 1'b1;
                end
            end
        end
    end

    // Reader next-state and tx-facing outputs; data is zeroed outside FEED.
    always_comb begin
        stateNext         = state;
        txReqSendPacket_o = 1'b0;
        txDataValid_o     = 1'b0;
        txIsLastByte_o    = 1'b0;
        txData_o          = '0;
        sendDone_o        = 1'b0;
        case (state)
            IDLE: begin
                if (pktCount != '0) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                txReqSendPacket_o = 1'b1;
                stateNext         = FEED;
            end
            FEED: begin
                txDataValid_o  = 1'b1;
                txData_o       = rdEntry[7:0];
                txIsLastByte_o = rdEntry[8];
                if (txAcceptNewData_i && rdEntry[8]) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (seen && !txSending_i) begin
                    sendDone_o = 1'b1;
                    stateNext  = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_packet_buf.sv
// Self-checking bench for usb_tx_packet_buf: a queue-based model of committed
// and pending bytes predicts the transmitted stream, counts and ready.
module tb_usb_tx_packet_buf;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef logic [8:0] ent_t;

    logic          clk48_i           = 1'b0;
    logic          rst_n_i           = 1'b0;
    logic [7:0]    wrData_i          = '0;
    logic          wrValid_i         = 1'b0;
    logic          wrLast_i          = 1'b0;
    logic          wrDiscard_i       = 1'b0;
    logic          wrReady_o;
    logic          wrOverflow_o;
    logic [AW:0]   pktCount_o;
    logic          txReqSendPacket_o;
    logic          txAcceptNewData_i = 1'b0;
    logic          txDataValid_o;
    logic          txIsLastByte_o;
    logic [7:0]    txData_o;
    logic          txSending_i       = 1'b0;
    logic          sendDone_o;

    usb_tx_packet_buf #(.DEPTH(DEPTH)) dut (
        .clk48_i           (clk48_i),
        .rst_n_i           (rst_n_i),
        .wrData_i          (wrData_i),
        .wrValid_i         (wrValid_i),
        .wrLast_i          (wrLast_i),
        .wrDiscard_i       (wrDiscard_i),
        .wrReady_o         (wrReady_o),
        .wrOverflow_o      (wrOverflow_o),
        .pktCount_o        (pktCount_o),
        .txReqSendPacket_o (txReqSendPacket_o),
        .txAcceptNewData_i (txAcceptNewData_i),
        .txDataValid_o     (txDataValid_o),
        .txIsLastByte_o    (txIsLastByte_o),
        .txData_o          (txData_o),
        .txSending_i       (txSending_i),
        .sendDone_o        (sendDone_o)
    );

    always #10 clk48_i = ~clk48_i;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int reqCount    = 0;
    int doneCount   = 0;
    int ovfCount    = 0;
    int handledReq  = 0;
    int reqCyc      = -1000;
    int doneCyc     = -1000;
    int lastWrCyc   = 0;

    // Reference model: committed-unsent bytes, bytes of the open packet,
    // and number of committed-unsent packets.
    ent_t expQ[$];
    ent_t pend[$];
    int   expPkts = 0;

    always @(posedge clk48_i) cyc <= cyc + 1;

    // Pulse bookkeeping sampled mid-cycle.
    always @(negedge clk48_i) begin
        if (txReqSendPacket_o) begin
            reqCount++;
            reqCyc = cyc;
        end
        if (sendDone_o) begin
            doneCount++;
            doneCyc = cyc;
        end
        if (wrOverflow_o) ovfCount++;
    end

    task automatic tick();
        @(posedge clk48_i);
        #1;
    endtask

    // One write-side cycle; the model decides ready/accept from its own state.
    task automatic wr_cycle(input bit v, input logic [7:0] d, input bit l,
                            input bit disc, output bit rdyObs, output bit rdyExp);
        int occ;
        tick();
        wrValid_i         = v;
        wrData_i          = d;
        wrLast_i          = l;
        wrDiscard_i       = disc;
        txAcceptNewData_i = 1'b0;
        occ    = expQ.size() + pend.size();
        rdyExp = (occ < DEPTH) && !disc;
        @(negedge clk48_i);
        rdyObs = wrReady_o;
        if (disc) begin
            pend.delete();
        end else if (occ == DEPTH && expQ.size() == 0) begin
            pend.delete();
        end else if (v && rdyExp) begin
            pend.push_back({l, d});
            if (l) begin
                foreach (pend[i]) expQ.push_back(pend[i]);
                pend.delete();
                expPkts++;
                lastWrCyc = cyc;
            end
        end
    endtask

    task automatic wr_packet(input ent_t bytes[$], output int bad);
        bit o, e;
        bad = 0;
        foreach (bytes[i]) begin
            wr_cycle(1'b1, bytes[i][7:0], bytes[i][8], 1'b0, o, e);
            if (o !== e) bad++;
        end
    endtask

    // Plays the tx engine for one packet. mode 0: accept every other cycle,
    // otherwise accept with the given percentage.
    task automatic test_packet_send(input string tag, input int unsigned pct);
        int   t;
        int   drops;
        int   doneBase;
        bit   done;
        bit   gotDone;
        ent_t exp;
        ent_t obs;
        tick();
        wrValid_i = 1'b0; wrLast_i = 1'b0; wrDiscard_i = 1'b0; txAcceptNewData_i = 1'b0;
        t = 0;
        while (reqCount <= handledReq && t < 100) begin
            tick();
            t++;
        end
        vectors++;
        if (reqCount != handledReq + 1) begin
            miscompares++;
            $display("FAIL %s.req_count: got %0d want %0d", tag, reqCount - handledReq, 1);
        end
        vectors++;
        if (reqCyc - doneCyc < 2) begin
            miscompares++;
            $display("FAIL %s.req_spacing: got %0d cycles after done want >=2", tag, reqCyc - doneCyc);
        end
        handledReq  = reqCount;
        txSending_i = 1'b1;
        done  = 1'b0;
        drops = 0;
        t     = 0;
        while (!done && t < 300) begin
            if (t > 0) tick();
            txAcceptNewData_i = (pct == 0) ? ((t % 2) == 1) : ($urandom_range(99) < pct);
            @(negedge clk48_i);
            if (txDataValid_o !== 1'b1) drops++;
            if (txAcceptNewData_i && txDataValid_o) begin
                obs = {txIsLastByte_o, txData_o};
                if (expQ.size() == 0) begin
                    exp  = 'x;
                    done = 1'b1;
                end else begin
                    exp = expQ.pop_front();
                    if (exp[8]) begin
                        done = 1'b1;
                        expPkts--;
                    end
                end
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL %s.byte: got last=%b data=%h want last=%b data=%h",
                             tag, obs[8], obs[7:0], exp[8], exp[7:0]);
                end
            end
            t++;
        end
        vectors++;
        if (!done || drops != 0) begin
            miscompares++;
            $display("FAIL %s.feed: got done=%0b valid_drops=%0d want done=1 valid_drops=0", tag, done, drops);
        end
        tick();
        txAcceptNewData_i = 1'b0;
        @(negedge clk48_i);
        vectors++;
        if ({txDataValid_o, sendDone_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s.drain_entry: got valid=%b done=%b want 0 0", tag, txDataValid_o, sendDone_o);
        end
        tick();
        doneBase    = doneCount;
        tick();
        txSending_i = 1'b0;
        gotDone = 1'b0;
        t = 0;
        while (!gotDone && t < 5) begin
            @(negedge clk48_i);
            if (sendDone_o) gotDone = 1'b1;
            else tick();
            t++;
        end
        repeat (3) tick();
        vectors++;
        if (!gotDone || doneCount != doneBase + 1) begin
            miscompares++;
            $display("FAIL %s.send_done: got %0d pulses want 1", tag, doneCount - doneBase);
        end
        vectors++;
        if (pktCount_o !== (AW + 1)'(expPkts)) begin
            miscompares++;
            $display("FAIL %s.pkt_count: got %0d want %0d", tag, pktCount_o, expPkts);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk48_i);
        #1;
        vectors++;
        if ({txReqSendPacket_o, txDataValid_o, txIsLastByte_o, txData_o, sendDone_o, wrOverflow_o} !== '0) begin
            miscompares++;
            $display("FAIL reset.outputs: got req=%b val=%b last=%b data=%h done=%b ovf=%b want all 0",
                     txReqSendPacket_o, txDataValid_o, txIsLastByte_o, txData_o, sendDone_o, wrOverflow_o);
        end
        vectors++;
        if (pktCount_o !== '0 || wrReady_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset.counts: got pkt=%0d ready=%b want 0 1", pktCount_o, wrReady_o);
        end
        @(negedge clk48_i);
        rst_n_i = 1'b1;
    endtask

    task automatic test_basic();
        ent_t q[$];
        int   bad;
        q = '{9'h0C3, 9'h001, 9'h102};
        wr_packet(q, bad);
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL basic.wr_ready: got %0d stalls want 0", bad);
        end
        test_packet_send("basic", 0);
        vectors++;
        if (reqCyc != lastWrCyc + 2) begin
            miscompares++;
            $display("FAIL basic.req_latency: got %0d want %0d", reqCyc - lastWrCyc, 2);
        end
    endtask

    task automatic test_single_byte();
        ent_t q[$];
        int   bad;
        q = '{9'h1D2};
        wr_packet(q, bad);
        test_packet_send("single", 100);
    endtask

    task automatic test_back_to_back();
        ent_t q[$];
        int   bad;
        bit   o, e;
        q = '{9'h0C3, 9'h0A1, 9'h1A2};
        wr_packet(q, bad);
        q = '{9'h04B, 9'h0B1, 9'h0B2, 9'h0B3, 9'h1B4};
        wr_packet(q, bad);
        wr_cycle(1'b0, 8'h00, 1'b0, 1'b0, o, e);
        vectors++;
        if (pktCount_o !== (AW + 1)'(2)) begin
            miscompares++;
            $display("FAIL b2b.pkt_count: got %0d want 2", pktCount_o);
        end
        test_packet_send("b2b_first", 100);
        test_packet_send("b2b_second", 60);
    endtask

    task automatic test_overflow();
        ent_t q[$];
        int   bad;
        int   ovfBase;
        bit   o, e;
        ovfBase = ovfCount;
        bad = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            wr_cycle(1'b1, 8'(i), 1'b0, 1'b0, o, e);
            if (o !== e) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL ovf.fill_ready: got %0d stalls want 0", bad);
        end
        wr_cycle(1'b1, 8'hEE, 1'b0, 1'b0, o, e);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL ovf.full_ready: got %b want %b", o, e);
        end
        wr_cycle(1'b0, 8'h00, 1'b0, 1'b0, o, e);
        vectors++;
        if (wrOverflow_o !== 1'b1 || o !== e) begin
            miscompares++;
            $display("FAIL ovf.pulse: got ovf=%b ready=%b want ovf=1 ready=%b", wrOverflow_o, o, e);
        end
        wr_cycle(1'b0, 8'h00, 1'b0, 1'b0, o, e);
        tick();
        vectors++;
        if (ovfCount != ovfBase + 1) begin
            miscompares++;
            $display("FAIL ovf.pulse_count: got %0d want 1", ovfCount - ovfBase);
        end
        q = '{9'h0E1, 9'h011, 9'h022, 9'h133};
        wr_packet(q, bad);
        test_packet_send("ovf_after", 70);
    endtask

    task automatic test_discard();
        ent_t q[$];
        int   bad;
        bit   o, e;
        q = '{9'h0C3, 9'h055, 9'h066};
        foreach (q[i]) wr_cycle(1'b1, q[i][7:0], 1'b0, 1'b0, o, e);
        wr_cycle(1'b1, 8'hAA, 1'b1, 1'b1, o, e);
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL discard.ready: got %b want %b", o, e);
        end
        repeat (5) wr_cycle(1'b0, 8'h00, 1'b0, 1'b0, o, e);
        vectors++;
        if (pktCount_o !== (AW + 1)'(expPkts) || reqCount != handledReq) begin
            miscompares++;
            $display("FAIL discard.no_send: got pkt=%0d reqs=%0d want pkt=%0d reqs=0",
                     pktCount_o, reqCount - handledReq, expPkts);
        end
        q = '{9'h04B, 9'h011, 9'h122};
        wr_packet(q, bad);
        test_packet_send("discard_next", 80);
    endtask

    task automatic test_reset_mid_feed();
        ent_t q[$];
        int   bad;
        int   t;
        bit   o, e;
        q = '{9'h0C3, 9'h071, 9'h072, 9'h073, 9'h074, 9'h175};
        wr_packet(q, bad);
        tick();
        wrValid_i = 1'b0; wrLast_i = 1'b0;
        t = 0;
        while (reqCount <= handledReq && t < 100) begin
            tick();
            t++;
        end
        handledReq        = reqCount;
        txSending_i       = 1'b1;
        txAcceptNewData_i = 1'b1;
        repeat (2) @(posedge clk48_i);
        #3;
        txAcceptNewData_i = 1'b0;
        rst_n_i           = 1'b0;
        #1;
        vectors++;
        if ({txReqSendPacket_o, txDataValid_o, txIsLastByte_o, txData_o, sendDone_o, wrOverflow_o, pktCount_o} !== '0) begin
            miscompares++;
            $display("FAIL rst_feed.async: got req=%b val=%b last=%b data=%h done=%b ovf=%b pkt=%0d want all 0",
                     txReqSendPacket_o, txDataValid_o, txIsLastByte_o, txData_o, sendDone_o, wrOverflow_o, pktCount_o);
        end
        expQ.delete();
        pend.delete();
        expPkts     = 0;
        txSending_i = 1'b0;
        repeat (2) @(posedge clk48_i);
        @(negedge clk48_i);
        rst_n_i = 1'b1;
        repeat (10) wr_cycle(1'b0, 8'h00, 1'b0, 1'b0, o, e);
        vectors++;
        if (pktCount_o !== '0 || wrReady_o !== 1'b1 || reqCount != handledReq) begin
            miscompares++;
            $display("FAIL rst_feed.after: got pkt=%0d ready=%b reqs=%0d want 0 1 0",
                     pktCount_o, wrReady_o, reqCount - handledReq);
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        int   bad;
        int   npk;
        int   len;
        bit   o, e;
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(1) == 1) begin
                len = $urandom_range(1, 5);
                for (int i = 0; i < len; i++) wr_cycle(1'b1, 8'($urandom), 1'b0, 1'b0, o, e);
                wr_cycle(1'b0, 8'h00, 1'b0, 1'b1, o, e);
            end
            npk = $urandom_range(1, 2);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 12);
                q.delete();
                for (int i = 0; i < len; i++) q.push_back({(i == len - 1), 8'($urandom)});
                wr_packet(q, bad);
            end
            wr_cycle(1'b0, 8'h00, 1'b0, 1'b0, o, e);
            vectors++;
            if (pktCount_o !== (AW + 1)'(npk)) begin
                miscompares++;
                $display("FAIL random.pkt_count: got %0d want %0d", pktCount_o, npk);
            end
            for (int p = 0; p < npk; p++) test_packet_send("random", $urandom_range(25, 100));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_discard();
        test_random();
        test_reset_mid_feed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
